segway_drive_seq: RTL
=====================

Name: segway_drive_seq

Overview:
Sequencer for the balance-math datapath. Generates pwr_up, the soft-start ramp ss_tmr and a qualified en_steer. It also delays the sample strobe to match math pipeline latency and supervises too_fast into a fault/alarm state. Sits between the auth/rider-detect logic and the math block; its outputs feed the math block directly.

Parameters:
SS_PRESCALE, 8, log2 of clocks per ss_tmr increment/decrement step (1..16)
SS_MAX, 8'hFF, ss_tmr value at which ramp-up completes
FAST_LIMIT, 4, consecutive qualified too_fast samples needed to enter FAULT; also consecutive clean samples needed to leave it (1..15)
MATH_LAT, 2, clock latency of the math datapath (0 = combinational build, 2 = pipelined build)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
pwr_up_req  in  1  level request to power the drive (from auth)
en_steer_req  in  1  rider-weight steering enable request
vld  in  1  one-cycle strobe: new PID_cntrl/steer_pot sample presented to math
too_fast  in  1  from math block
pwr_up  out  1  drive power-up to math
ss_tmr  out  8  soft-start scale to math
en_steer  out  1  qualified steering enable to math
math_vld  out  1  vld delayed MATH_LAT clocks (math outputs valid)
fault  out  1  overspeed fault/alarm flag
state_o  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst_n==0 at posedge): state=IDLE, pwr_up=0, ss_tmr=0, en_steer=0, math_vld=0, fault=0, prescaler=0, fast_cnt=0, vld delay line cleared. Reset mid-ramp or mid-fault aborts immediately next edge.
- All outputs registered; state change visible one clock after the qualifying condition.
- Prescaler: SS_PRESCALE-bit up counter, runs only in RAMP (and RAMPDN); tick when all ones; cleared on entry to RAMP/RAMPDN.
- IDLE: pwr_up=0, ss_tmr=0, en_steer=0, fault=0. pwr_up_req=1 -> RAMP.
- RAMP: pwr_up=1, en_steer=0. On tick, ss_tmr+=1, saturating at SS_MAX. ss_tmr==SS_MAX -> RUN. pwr_up_req=0 -> IDLE (ss_tmr cleared) or RAMPDN with the optional feature.
- RUN: pwr_up=1, ss_tmr=SS_MAX, en_steer=en_steer_req registered. fast_cnt counts consecutive math_vld cycles with too_fast=1 and clears on math_vld with too_fast=0. fast_cnt reaches FAST_LIMIT -> FAULT. pwr_up_req=0 -> IDLE/RAMPDN; power-down has priority over fault on the same cycle.
- FAULT: fault=1, pwr_up=1, ss_tmr held, en_steer forced 0. fast_cnt now counts consecutive clean math_vld samples; FAST_LIMIT clean -> RUN with fault=0, fast_cnt=0. pwr_up_req=0 -> IDLE/RAMPDN, fault cleared.
- too_fast is ignored outside RUN/FAULT and on cycles without math_vld.
- math_vld: shift register of depth MATH_LAT; MATH_LAT=0 means math_vld=vld (combinational pass). Runs in every state, including IDLE.
- Encodings: IDLE=0, RAMP=1, RUN=2, FAULT=3, RAMPDN=4.

Optional Feature:
SEGWAY_RAMPDN_EN
- With it: pwr_up_req=0 from RAMP/RUN/FAULT enters RAMPDN. pwr_up stays 1, en_steer=0, fault=0, and ss_tmr decrements 1 per tick. When ss_tmr==0 -> IDLE. pwr_up_req=1 during RAMPDN -> RAMP, resuming from the current ss_tmr.
- Without it: RAMPDN is not generated; power-down goes straight to IDLE with ss_tmr=0 and pwr_up=0 on the next edge.

Decomposition:
- Package segway_pkg holds:
  - the state enum typedef (3-bit)
  - SS_MAX_DEF, FAST_LIMIT_DEF
  - MATH_LAT_PIPE=2 and MATH_LAT_COMB=0 constants, shared with the math block's PIPELINED selection.
- One sub-module: segway_vld_dly (parameterised-depth strobe delay line, MATH_LAT=0 pass-through).

Test Plan:
- SS_PRESCALE=2, assert pwr_up_req -> pwr_up=1 next clk; ss_tmr steps every 4 clks; reaches 8'hFF after 1020 clks; state RUN; en_steer follows en_steer_req one clk later.
- In RUN, FAST_LIMIT=4, MATH_LAT=2, vld every 10 clks with too_fast=1 on 3 samples, then 0, then 4 in a row -> no fault after 3; fault=1 one clk after 4th math_vld; en_steer=0.
- In FAULT, 3 clean samples, 1 dirty, 4 clean -> stays FAULT until 4th consecutive clean, then fault=0, state RUN.
- Drop pwr_up_req at ss_tmr=8'h40 mid-ramp. Without macro: pwr_up=0, ss_tmr=0 next clk. With SEGWAY_RAMPDN_EN: ss_tmr decrements to 0 over 256 clks, then IDLE; re-request at ss_tmr=8'h20 resumes RAMP from 8'h20.
- rst_n=0 for one clk during FAULT with vld pulses in flight -> all outputs 0 next clk, math_vld suppressed for delayed pulses, state IDLE.
- MATH_LAT=0 build: vld pulse -> math_vld same cycle; too_fast sampled on that cycle.

Source files
------------

// File: rtl/segway_pkg.sv
// segway_pkg: state type and shared constants for the drive sequencer
// and the balance-math block (MATH_LAT_* selects its PIPELINED build).
package segway_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_RUN    = 3'd2,
    S_FAULT  = 3'd3,
    S_RAMPDN = 3'd4
  } seq_state_t;

  localparam logic [7:0] SS_MAX_DEF = 8'hFF;
  localparam int FAST_LIMIT_DEF = 4;
  localparam int MATH_LAT_PIPE = 2;
  localparam int MATH_LAT_COMB = 0;

endpackage

// File: rtl/segway_vld_dly.sv
// segway_vld_dly: DEPTH-stage strobe delay line, DEPTH=0 is a wire.
// Ports: clk, rst_n (sync, active low), d (strobe in), q (delayed).
module segway_vld_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0] sr;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/segway_drive_seq.sv
// segway_drive_seq: power-up / soft-start / overspeed sequencer that
// feeds the balance-math block. Optional macro: SEGWAY_RAMPDN_EN.
// In : clk, rst_n (sync, active low), pwr_up_req, en_steer_req,
//      vld (sample strobe), too_fast (from math)
// Out: pwr_up, ss_tmr[7:0], en_steer, math_vld, fault, state_o[2:0]
module segway_drive_seq
  import segway_pkg::*;
#(
  parameter int         SS_PRESCALE = 8,
  parameter logic [7:0] SS_MAX      = SS_MAX_DEF,
  parameter int         FAST_LIMIT  = FAST_LIMIT_DEF,
  parameter int         MATH_LAT    = MATH_LAT_PIPE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_up_req,
  input  logic       en_steer_req,
  input  logic       vld,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       math_vld,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [SS_PRESCALE-1:0] P_ONE = SS_PRESCALE'(1);
  localparam logic [3:0] LIM = 4'(FAST_LIMIT);

`ifdef SEGWAY_RAMPDN_EN
  localparam seq_state_t OFF_ST = S_RAMPDN;
`else
  localparam seq_state_t OFF_ST = S_IDLE;
`endif

  seq_state_t state, state_d;

  logic [SS_PRESCALE-1:0] presc, presc_d;
  logic [3:0] fast_cnt, fast_cnt_d, cnt_inc;
  logic [7:0] ss_d;
  logic tick, hot, clean, stay;

  segway_vld_dly #(
    .DEPTH(MATH_LAT)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (vld),
    .q    (math_vld)
  );

  always_comb begin
    state_d = state;
    tick    = &presc;
    hot     = math_vld & too_fast;
    clean   = math_vld & ~too_fast;
    cnt_inc = fast_cnt + 4'd1;
    unique case (state)
      S_IDLE:
        if (pwr_up_req) state_d = S_RAMP;
      S_RAMP:
        if (!pwr_up_req) state_d = OFF_ST;
        else if (ss_tmr == SS_MAX) state_d = S_RUN;
      S_RUN:
        if (!pwr_up_req) state_d = OFF_ST;
        else if (hot && cnt_inc == LIM) state_d = S_FAULT;
      S_FAULT:
        if (!pwr_up_req) state_d = OFF_ST;
        else if (clean && cnt_inc == LIM) state_d = S_RUN;
      S_RAMPDN:
        if (pwr_up_req) state_d = S_RAMP;
        else if (ss_tmr == 8'd0) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Counters and the ramp only advance while the state holds;
  // any transition restarts them from zero (ss_tmr is kept).
  always_comb begin
    stay       = (state_d == state);
    presc_d    = '0;
    fast_cnt_d = '0;
    ss_d       = ss_tmr;
    if (stay && (state == S_RAMP || state == S_RAMPDN))
      presc_d = presc + P_ONE;
    if (stay && state == S_RUN)
      fast_cnt_d = hot ? cnt_inc : (clean ? 4'd0 : fast_cnt);
    if (stay && state == S_FAULT)
      fast_cnt_d = clean ? cnt_inc : (hot ? 4'd0 : fast_cnt);
    if (state_d == S_IDLE)
      ss_d = 8'd0;
    else if (stay && state == S_RAMP && tick && ss_tmr != SS_MAX)
      ss_d = ss_tmr + 8'd1;
    else if (stay && state == S_RAMPDN && tick && ss_tmr != 8'd0)
      ss_d = ss_tmr - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      fast_cnt <= '0;
      ss_tmr   <= 8'd0;
      pwr_up   <= 1'b0;
      en_steer <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_d;
      presc    <= presc_d;
      fast_cnt <= fast_cnt_d;
      ss_tmr   <= ss_d;
      pwr_up   <= (state_d != S_IDLE);
      en_steer <= (state_d == S_RUN) & en_steer_req;
      fault    <= (state_d == S_FAULT);
    end
  end

  assign state_o = state;

endmodule
